// File: rtl/rv32_pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32 core: stage enables, bubble/flush controls,
// EX operand forwarding, sticky halt and data-memory timeout reporting.
module rv32_pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_use_rs1,
   input  logic       id_use_rs2,
   input  logic [4:0] ex_rd,
   input  logic       ex_is_load,
   input  logic [4:0] ex_rs1,
   input  logic [4:0] ex_rs2,
   input  logic [4:0] mem_rd,
   input  logic       mem_rf_we,
   input  logic [4:0] wb_rd,
   input  logic       wb_rf_we,
   input  logic       ex_redirect,
   input  logic       dmem_req,
   input  logic       dmem_ready,
   input  logic       wb_hlt,
   output logic       pc_en,
   output logic       if_id_en,
   output logic       id_ex_en,
   output logic       ex_mem_en,
   output logic       mem_wb_en,
   output logic       if_id_flush,
   output logic       id_ex_flush,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b,
   output logic       halted,
   output logic       mem_err
);

   typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT, HALT} state_e;

   localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

   if (MEM_TIMEOUT == 0 || MEM_TIMEOUT > 255) begin : g_bad_timeout
      $error("MEM_TIMEOUT must lie in 1..255");
   end
   if (NOP_INSTR[1:0] != 2'b11) begin : g_bad_nop
      $error("NOP_INSTR is not a 32-bit RISC-V encoding");
   end

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       mem_err_q, mem_err_d;
   logic       mem_stall;
   logic       load_use;

   assign mem_stall = dmem_req & ~dmem_ready;
   assign load_use  = ex_is_load && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      logic [1:0] sel;
      sel = 2'b00;
      if (mem_rf_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
         sel = 2'b01;
      end else if (wb_rf_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
         sel = 2'b10;
      end
      return sel;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RUN;
         cnt_q     <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mem_err_q <= mem_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_err_d = mem_err_q;
      case (state_q)
         RUN, LOAD_STALL: begin
            if (mem_stall) begin
               state_d = MEM_WAIT;
               cnt_d   = 8'd1;
            end else if ((state_q == RUN) && !ex_redirect && load_use) begin
               state_d = LOAD_STALL;
            end else begin
               state_d = RUN;
            end
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         HALT: state_d = HALT;
      endcase
      // Timeout check covers both wait entry and continuation, so MEM_TIMEOUT=1 works.
      if ((state_d == MEM_WAIT) && (cnt_d >= TIMEOUT_C)) begin
         mem_err_d = 1'b1;
         state_d   = HALT;
      end
      if (wb_hlt) begin
         state_d = HALT;
      end
   end

   always_comb begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      halted      = 1'b0;
      if (rst_n) begin
         case (state_q)
            RUN: begin
               if (!mem_stall) begin
                  {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
                  if (ex_redirect) begin
                     if_id_flush = 1'b1;
                     id_ex_flush = 1'b1;
                  end else if (load_use) begin
                     pc_en       = 1'b0;
                     if_id_en    = 1'b0;
                     id_ex_flush = 1'b1;
                  end
               end
            end
            LOAD_STALL: begin
               if (!mem_stall) begin
                  {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
               end
            end
            MEM_WAIT: begin
               if (dmem_ready) begin
                  {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
               end
            end
            HALT: halted = 1'b1;
         endcase
      end
   end

   assign fwd_a   = rst_n ? fwd_sel(ex_rs1) : 2'b00;
   assign fwd_b   = rst_n ? fwd_sel(ex_rs2) : 2'b00;
   assign mem_err = mem_err_q;

endmodule

// File: tb/tb_rv32_pipe_hazard_ctrl.sv
// Self-checking bench for rv32_pipe_hazard_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural pipeline-mode model.
module tb_rv32_pipe_hazard_ctrl;

   localparam int unsigned TO = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
   logic       id_use_rs1, id_use_rs2, ex_is_load, mem_rf_we, wb_rf_we;
   logic       ex_redirect, dmem_req, dmem_ready, wb_hlt;
   logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic       if_id_flush, id_ex_flush, halted, mem_err;
   logic [1:0] fwd_a, fwd_b;

   int unsigned errors = 0;
   int unsigned checks = 0;

   // Model: halted, waiting on memory (with elapsed wait cycles), bubble just inserted
   bit          m_halted, m_wait, m_bubble, m_err;
   int unsigned m_cnt;

   always #5 clk = ~clk;

   rv32_pipe_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .mem_rd(mem_rd), .mem_rf_we(mem_rf_we), .wb_rd(wb_rd), .wb_rf_we(wb_rf_we),
      .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready), .wb_hlt(wb_hlt),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .mem_err(mem_err)
   );

   function automatic logic [12:0] dut_vec();
      return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
              fwd_a, fwd_b, halted, mem_err};
   endfunction

   function automatic logic [6:0] ctrl7();
      return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};
   endfunction

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (rs == 5'd0) return 2'b00;
      if (mem_rf_we && mem_rd == rs) return 2'b01;
      if (wb_rf_we && wb_rd == rs) return 2'b10;
      return 2'b00;
   endfunction

   function automatic bit ref_load_use();
      return ex_is_load && (ex_rd != 5'd0) &&
             ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
   endfunction

   function automatic logic [12:0] ref_vec();
      logic [4:0] en;
      logic [1:0] fl;
      if (!rst_n) return '0;
      en = 5'b11111;
      fl = 2'b00;
      if (m_halted) en = 5'b00000;
      else if (m_wait) en = dmem_ready ? 5'b11111 : 5'b00000;
      else if (dmem_req && !dmem_ready) en = 5'b00000;
      else if (!m_bubble && ex_redirect) fl = 2'b11;
      else if (!m_bubble && ref_load_use()) begin
         en = 5'b00111;
         fl = 2'b01;
      end
      return {en, fl, ref_fwd(ex_rs1), ref_fwd(ex_rs2), m_halted, m_err};
   endfunction

   task automatic model_reset();
      m_halted = 0; m_wait = 0; m_bubble = 0; m_err = 0; m_cnt = 0;
   endtask

   task automatic clear_inputs();
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0; ex_rs1 = '0; ex_rs2 = '0; mem_rd = '0; wb_rd = '0;
      id_use_rs1 = 0; id_use_rs2 = 0; ex_is_load = 0; mem_rf_we = 0; wb_rf_we = 0;
      ex_redirect = 0; dmem_req = 0; dmem_ready = 0; wb_hlt = 0;
   endtask

   // Advance the model with the inputs present before the edge, then clock the DUT.
   task automatic tick();
      bit lu;
      lu = ref_load_use();
      if (rst_n && !m_halted) begin
         if (m_wait) begin
            if (dmem_ready) m_wait = 0;
            else begin
               m_cnt++;
               if (m_cnt >= TO) begin m_err = 1; m_halted = 1; end
            end
         end else if (dmem_req && !dmem_ready) begin
            m_wait = 1; m_cnt = 1; m_bubble = 0;
            if (m_cnt >= TO) begin m_err = 1; m_halted = 1; end
         end else begin
            m_bubble = !m_bubble && !ex_redirect && lu;
         end
         if (wb_hlt) m_halted = 1;
      end
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 0;
      clear_inputs();
      model_reset();
      #1;
      rst_n = 1;
      #1;
   endtask

   task automatic set_load_use_hazard();
      ex_is_load = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
   endtask

   task automatic test_reset();
      clear_inputs();
      model_reset();
      mem_rf_we = 1; mem_rd = 5'd7; ex_rs1 = 5'd7;
      rst_n = 0;
      #1;
      checks++;
      if (dut_vec() !== 13'h0) begin
         errors++; $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 13'h0);
      end
      tick();
      checks++;
      if (dut_vec() !== 13'h0) begin
         errors++; $display("FAIL reset_after_edge: got %h expected %h", dut_vec(), 13'h0);
      end
      rst_n = 1;
      #1;
      checks++;
      if (dut_vec() !== 13'b11111_00_01_00_0_0) begin
         errors++; $display("FAIL reset_release: got %b expected %b", dut_vec(), 13'b11111_00_01_00_0_0);
      end
   endtask

   task automatic test_load_use();
      clear_inputs();
      set_load_use_hazard();
      #1;
      checks++;
      if (ctrl7() !== 7'b0011101) begin
         errors++; $display("FAIL load_use_stall: got %b expected %b", ctrl7(), 7'b0011101);
      end
      tick();
      checks++;
      if (ctrl7() !== 7'b1111100) begin
         errors++; $display("FAIL load_use_bubble: got %b expected %b", ctrl7(), 7'b1111100);
      end
      tick();
      #1;
      checks++;
      if (ctrl7() !== 7'b0011101) begin
         errors++; $display("FAIL load_use_back_in_run: got %b expected %b", ctrl7(), 7'b0011101);
      end
      clear_inputs();
      tick();
      tick();
   endtask

   task automatic test_redirect_over_load_use();
      clear_inputs();
      set_load_use_hazard();
      ex_redirect = 1;
      #1;
      checks++;
      if (ctrl7() !== 7'b1111111) begin
         errors++; $display("FAIL redirect_flush: got %b expected %b", ctrl7(), 7'b1111111);
      end
      tick();
      ex_redirect = 0;
      #1;
      checks++;
      if (ctrl7() !== 7'b0011101) begin
         errors++; $display("FAIL redirect_no_bubble: got %b expected %b", ctrl7(), 7'b0011101);
      end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_mem_wait();
      clear_inputs();
      dmem_req = 1; dmem_ready = 0; ex_redirect = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (ctrl7() !== 7'b0000000) begin
            errors++; $display("FAIL mem_wait_frozen[%0d]: got %b expected %b", i, ctrl7(), 7'b0);
         end
         tick();
      end
      dmem_ready = 1;
      #1;
      checks++;
      if ({ctrl7(), mem_err} !== 8'b1111100_0) begin
         errors++; $display("FAIL mem_wait_ready: got %b expected %b", {ctrl7(), mem_err}, 8'b1111100_0);
      end
      tick();
      clear_inputs();
      #1;
      checks++;
      if (dut_vec() !== ref_vec()) begin
         errors++; $display("FAIL mem_wait_resume: got %b expected %b", dut_vec(), ref_vec());
      end
   endtask

   task automatic test_forwarding();
      logic [4:0] rd_tab [3];
      logic       mwe_tab[3];
      logic [3:0] exp_tab[3];
      rd_tab  = '{5'd3, 5'd3, 5'd0};
      mwe_tab = '{1'b1, 1'b0, 1'b1};
      exp_tab = '{4'b0101, 4'b1010, 4'b0000};
      clear_inputs();
      for (int i = 0; i < 3; i++) begin
         ex_rs1 = rd_tab[i]; ex_rs2 = rd_tab[i];
         mem_rd = rd_tab[i]; wb_rd = rd_tab[i];
         mem_rf_we = mwe_tab[i]; wb_rf_we = 1;
         #1;
         checks++;
         if ({fwd_a, fwd_b} !== exp_tab[i]) begin
            errors++; $display("FAIL fwd_table[%0d]: got %b expected %b", i, {fwd_a, fwd_b}, exp_tab[i]);
         end
      end
      for (int i = 0; i < 40; i++) begin
         ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
         mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
         mem_rf_we = 1'($urandom_range(0, 1)); wb_rf_we = 1'($urandom_range(0, 1));
         #1;
         checks++;
         if ({fwd_a, fwd_b} !== {ref_fwd(ex_rs1), ref_fwd(ex_rs2)}) begin
            errors++; $display("FAIL fwd_random[%0d]: got %b expected %b", i, {fwd_a, fwd_b},
                               {ref_fwd(ex_rs1), ref_fwd(ex_rs2)});
         end
      end
      clear_inputs();
   endtask

   task automatic test_timeout();
      do_reset();
      dmem_req = 1; dmem_ready = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if ({halted, mem_err} !== 2'b00) begin
            errors++; $display("FAIL timeout_early[%0d]: got %b expected %b", i, {halted, mem_err}, 2'b00);
         end
         tick();
      end
      #1;
      checks++;
      if ({ctrl7(), halted, mem_err} !== 9'b0000000_11) begin
         errors++; $display("FAIL timeout_hit: got %b expected %b", {ctrl7(), halted, mem_err}, 9'b0000000_11);
      end
      clear_inputs();
      dmem_ready = 1;
      tick(); tick(); tick();
      checks++;
      if ({ctrl7(), halted, mem_err} !== 9'b0000000_11) begin
         errors++; $display("FAIL timeout_sticky: got %b expected %b", {ctrl7(), halted, mem_err}, 9'b0000000_11);
      end
      do_reset();
      checks++;
      if ({ctrl7(), halted, mem_err} !== 9'b1111100_00) begin
         errors++; $display("FAIL timeout_cleared: got %b expected %b", {ctrl7(), halted, mem_err}, 9'b1111100_00);
      end
   endtask

   task automatic test_halt();
      clear_inputs();
      wb_hlt = 1;
      #1;
      checks++;
      if ({ctrl7(), halted} !== 8'b1111100_0) begin
         errors++; $display("FAIL halt_same_cycle: got %b expected %b", {ctrl7(), halted}, 8'b1111100_0);
      end
      tick();
      wb_hlt = 0;
      #1;
      checks++;
      if ({ctrl7(), halted} !== 8'b0000000_1) begin
         errors++; $display("FAIL halt_entered: got %b expected %b", {ctrl7(), halted}, 8'b0000000_1);
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      dmem_req = 1; dmem_ready = 0;
      tick();
      tick();
      rst_n = 0;
      #1;
      checks++;
      if (dut_vec() !== 13'h0) begin
         errors++; $display("FAIL async_reset_mid_wait: got %h expected %h", dut_vec(), 13'h0);
      end
      model_reset();
      clear_inputs();
      rst_n = 1;
      #1;
      checks++;
      if (ctrl7() !== 7'b1111100) begin
         errors++; $display("FAIL run_after_reset: got %b expected %b", ctrl7(), 7'b1111100);
      end
      tick();
      checks++;
      if (dut_vec() !== ref_vec()) begin
         errors++; $display("FAIL run_after_reset_edge: got %b expected %b", dut_vec(), ref_vec());
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
         ex_rd  = 5'($urandom_range(0, 3)); ex_rs1 = 5'($urandom_range(0, 3));
         ex_rs2 = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
         wb_rd  = 5'($urandom_range(0, 3));
         id_use_rs1 = 1'($urandom_range(0, 1)); id_use_rs2 = 1'($urandom_range(0, 1));
         ex_is_load = 1'($urandom_range(0, 1));
         mem_rf_we  = 1'($urandom_range(0, 1)); wb_rf_we = 1'($urandom_range(0, 1));
         ex_redirect = ($urandom_range(0, 5) == 0);
         dmem_req    = ($urandom_range(0, 3) == 0);
         dmem_ready  = ($urandom_range(0, 2) != 0);
         wb_hlt      = ($urandom_range(0, 59) == 0);
         #1;
         checks++;
         if (dut_vec() !== ref_vec()) begin
            errors++; $display("FAIL random[%0d]: got %b expected %b", i, dut_vec(), ref_vec());
         end
         tick();
         if (m_halted && $urandom_range(0, 3) == 0) do_reset();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_load_use();
      test_redirect_over_load_use();
      test_mem_wait();
      test_forwarding();
      test_timeout();
      test_halt();
      test_reset_mid_wait();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
